mmu_arbiter: RTL and testbench
==============================

MMU_ARBITER -- requirements
Module: mmu_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023, range 1..65535: BUSY cycles without mmu_mem_ready before a transaction is aborted.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports m0_req/m1_req, input, 1 each: level request from port 0 (CPU) and port 1 (debug).
REQ-005 SHALL have ports mN_we (1), mN_addr (32), mN_wdata (32), mN_width (2), mN_signed (1), all inputs per port N: write flag, address, write data, data width, signed read.
REQ-006 SHALL have ports mN_rdata (32), mN_ack (1), mN_err (1), all outputs per port N: read data, completion pulse, timeout pulse.
REQ-007 SHALL have outputs mmu_read_enable (1), mmu_write_enable (1), mmu_address (32), mmu_data_in (32), mmu_data_width (2), mmu_signed_read (1) to the MMU.
REQ-008 SHALL have inputs mmu_mem_ready (1) and mmu_data_out (32) from the MMU.

Function
REQ-009 SHALL implement states IDLE, BUSY and RESP, all outputs registered.
REQ-010 IDLE with no req asserted SHALL remain IDLE with both MMU enables low.
REQ-011 IDLE with at least one req SHALL select an owner (REQ-020), latch that port's we/addr/wdata/width/signed into the MMU outputs, and move to BUSY.
REQ-012 In BUSY, exactly one of mmu_read_enable/mmu_write_enable SHALL be high, selected by the latched we, and all MMU outputs SHALL stay stable.
REQ-013 In BUSY, mmu_mem_ready sampled high SHALL drop both enables, capture mmu_data_out into the owner's mN_rdata on reads only, and move to RESP.
REQ-014 RESP SHALL last exactly one cycle with the owner's mN_ack high, then return to IDLE.
REQ-015 Minimum latency SHALL be 3 cycles: req sampled at edge 0, enable high after edge 0, ready sampled at edge 1, ack high after edge 1 for one cycle.
REQ-016 A requester still holding req during or after RESP SHALL be treated as issuing a new request in the following IDLE cycle.
REQ-017 A 16-bit wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without ready; reaching TIMEOUT_CYCLES SHALL drop the enables and move to RESP with the owner's mN_err high instead of mN_ack, leaving mN_rdata unchanged.
REQ-018 Ready arriving in the same cycle the counter reaches TIMEOUT_CYCLES SHALL complete normally: ack, not err.
REQ-019 mmu_mem_ready and mmu_data_out SHALL be ignored outside BUSY, and req changes during BUSY/RESP SHALL not affect the transaction in flight.
REQ-020 Owner selection SHALL follow REQ-026/REQ-027; with a single request, that port SHALL always be granted.
REQ-021 mN_ack and mN_err SHALL never be high together, and SHALL never be high for a non-owner port.

Reset
REQ-022 reset_n low SHALL immediately force IDLE, both enables low, mmu_address/mmu_data_in/mmu_data_width/mmu_signed_read to 0, all mN_rdata to 0, all ack/err to 0, wait counter to 0, and last-grant to port 1.
REQ-023 Reset during BUSY SHALL abort the transaction with no ack or err, and the first post-reset IDLE SHALL arbitrate afresh.

Configuration
REQ-024 Macro MMU_ARBITER_RR_EN SHALL select the arbitration policy.
REQ-025 A 1-bit last-grant register SHALL record the owner of each accepted transaction.
REQ-026 With MMU_ARBITER_RR_EN defined, simultaneous requests SHALL be granted to the port not granted last (round-robin).
REQ-027 Without MMU_ARBITER_RR_EN, simultaneous requests SHALL always be granted to port 0 (fixed priority); last-grant is still maintained but unused.

Verification
REQ-028 Port 0 read: addr=0x10, width=2, MMU ready 2 cycles after enable with data 0xDEADBEEF -> m0_rdata=0xDEADBEEF, m0_ack 1 cycle, mmu_read_enable high exactly 3 cycles.
REQ-029 Port 1 write: addr=0x20, wdata=0x12345678, ready on first BUSY cycle -> mmu_write_enable high 1 cycle, mmu_data_in=0x12345678, m1_ack pulse, m1_rdata unchanged at 0.
REQ-030 Both reqs held for 4 transactions -> with RR_EN grants 0,1,0,1; without RR_EN grants 0,0,0,0.
REQ-031 TIMEOUT_CYCLES=8, ready never asserted -> enable drops after 8 BUSY cycles, m0_err pulses once, no ack; then a new request completes normally.
REQ-032 reset_n low in the 2nd BUSY cycle -> enables low asynchronously, no ack/err; after release, a held m1_req is granted and completes.

Source files
------------

// File: rtl/mmu_arbiter_if.sv
// mmu_arbiter_if: bundles the two requester ports and the MMU-side bus of
// the MMU arbiter. The arbiter uses the slave modport; requesters and the
// MMU model drive the master side.
`timescale 1ns/1ps

interface mmu_arbiter_if;
    // Port 0 (CPU)
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [1:0]  m0_width;
    logic        m0_signed;
    logic [31:0] m0_rdata;
    logic        m0_ack;
    logic        m0_err;
    // Port 1 (debug)
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [1:0]  m1_width;
    logic        m1_signed;
    logic [31:0] m1_rdata;
    logic        m1_ack;
    logic        m1_err;
    // MMU side
    logic        mmu_read_enable;
    logic        mmu_write_enable;
    logic [31:0] mmu_address;
    logic [31:0] mmu_data_in;
    logic [1:0]  mmu_data_width;
    logic        mmu_signed_read;
    logic        mmu_mem_ready;
    logic [31:0] mmu_data_out;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_width, m0_signed,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_width, m1_signed,
        input  mmu_mem_ready, mmu_data_out,
        output m0_rdata, m0_ack, m0_err,
        output m1_rdata, m1_ack, m1_err,
        output mmu_read_enable, mmu_write_enable, mmu_address,
        output mmu_data_in, mmu_data_width, mmu_signed_read
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_width, m0_signed,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_width, m1_signed,
        output mmu_mem_ready, mmu_data_out,
        input  m0_rdata, m0_ack, m0_err,
        input  m1_rdata, m1_ack, m1_err,
        input  mmu_read_enable, mmu_write_enable, mmu_address,
        input  mmu_data_in, mmu_data_width, mmu_signed_read
    );
endinterface

// File: rtl/mmu_arbiter.sv
// mmu_arbiter: two-port arbiter in front of a single MMU. One transaction at
// a time flows IDLE -> BUSY -> RESP; all outputs are registered. A BUSY phase
// that sees no mmu_mem_ready for TIMEOUT_CYCLES cycles is aborted with an
// error pulse instead of an ack.
// Build option: define MMU_ARBITER_RR_EN for round-robin arbitration between
// simultaneous requests; otherwise port 0 has fixed priority.
`timescale 1ns/1ps

module mmu_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic         clk,
    input  logic         reset_n,
    mmu_arbiter_if.slave bus
);

    // Counter value at which one more ready-less BUSY cycle means timeout.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_r, state_s;

    logic        rd_en_r, rd_en_s;
    logic        wr_en_r, wr_en_s;
    logic [31:0] addr_r, addr_s;
    logic [31:0] wdata_r, wdata_s;
    logic [1:0]  width_r, width_s;
    logic        sgn_r, sgn_s;
    logic        owner_r, owner_s;
    logic        last_grant_r, last_grant_s;
    logic [15:0] wait_cnt_r, wait_cnt_s;
    logic [31:0] rdata0_r, rdata0_s;
    logic [31:0] rdata1_r, rdata1_s;
    logic        ack0_r, ack0_s;
    logic        ack1_r, ack1_s;
    logic        err0_r, err0_s;
    logic        err1_r, err1_s;

    logic        any_req_s;
    logic        grant_s;
    logic        sel_we_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;
    logic [1:0]  sel_width_s;
    logic        sel_sgn_s;
    logic        timeout_hit_s;

    // Arbitration: choose the owner for a transaction that could start now
    // and mux that port's command fields.
    always_comb begin
        any_req_s = bus.m0_req | bus.m1_req;
        if (bus.m0_req && bus.m1_req) begin
`ifdef MMU_ARBITER_RR_EN
            grant_s = ~last_grant_r;
`else
            grant_s = 1'b0;
`endif
        end else if (bus.m0_req) begin
            grant_s = 1'b0;
        end else begin
            grant_s = 1'b1;
        end
        if (grant_s) begin
            sel_we_s    = bus.m1_we;
            sel_addr_s  = bus.m1_addr;
            sel_wdata_s = bus.m1_wdata;
            sel_width_s = bus.m1_width;
            sel_sgn_s   = bus.m1_signed;
        end else begin
            sel_we_s    = bus.m0_we;
            sel_addr_s  = bus.m0_addr;
            sel_wdata_s = bus.m0_wdata;
            sel_width_s = bus.m0_width;
            sel_sgn_s   = bus.m0_signed;
        end
        timeout_hit_s = (wait_cnt_r == TIMEOUT_LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; ready has priority over timeout in the same cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_s = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (bus.mmu_mem_ready || timeout_hit_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values of every registered output and the counter.
    always_comb begin
        rd_en_s      = rd_en_r;
        wr_en_s      = wr_en_r;
        addr_s       = addr_r;
        wdata_s      = wdata_r;
        width_s      = width_r;
        sgn_s        = sgn_r;
        owner_s      = owner_r;
        last_grant_s = last_grant_r;
        wait_cnt_s   = wait_cnt_r;
        rdata0_s     = rdata0_r;
        rdata1_s     = rdata1_r;
        ack0_s       = 1'b0;
        ack1_s       = 1'b0;
        err0_s       = 1'b0;
        err1_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    owner_s      = grant_s;
                    last_grant_s = grant_s;
                    rd_en_s      = ~sel_we_s;
                    wr_en_s      = sel_we_s;
                    addr_s       = sel_addr_s;
                    wdata_s      = sel_wdata_s;
                    width_s      = sel_width_s;
                    sgn_s        = sel_sgn_s;
                    wait_cnt_s   = 16'd0;
                end else begin
                    rd_en_s = 1'b0;
                    wr_en_s = 1'b0;
                end
            end
            ST_BUSY: begin
                if (bus.mmu_mem_ready) begin
                    rd_en_s = 1'b0;
                    wr_en_s = 1'b0;
                    // wr_en_r holds the latched write flag while BUSY.
                    if (!wr_en_r) begin
                        if (owner_r) begin
                            rdata1_s = bus.mmu_data_out;
                        end else begin
                            rdata0_s = bus.mmu_data_out;
                        end
                    end else begin
                        rdata0_s = rdata0_r;
                    end
                    if (owner_r) begin
                        ack1_s = 1'b1;
                    end else begin
                        ack0_s = 1'b1;
                    end
                end else if (timeout_hit_s) begin
                    rd_en_s    = 1'b0;
                    wr_en_s    = 1'b0;
                    wait_cnt_s = wait_cnt_r + 16'd1;
                    if (owner_r) begin
                        err1_s = 1'b1;
                    end else begin
                        err0_s = 1'b1;
                    end
                end else begin
                    wait_cnt_s = wait_cnt_r + 16'd1;
                end
            end
            ST_RESP: begin
                rd_en_s = 1'b0;
                wr_en_s = 1'b0;
            end
            default: begin
                rd_en_s = 1'b0;
                wr_en_s = 1'b0;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_en_r      <= 1'b0;
            wr_en_r      <= 1'b0;
            addr_r       <= 32'd0;
            wdata_r      <= 32'd0;
            width_r      <= 2'd0;
            sgn_r        <= 1'b0;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            wait_cnt_r   <= 16'd0;
            rdata0_r     <= 32'd0;
            rdata1_r     <= 32'd0;
            ack0_r       <= 1'b0;
            ack1_r       <= 1'b0;
            err0_r       <= 1'b0;
            err1_r       <= 1'b0;
        end else begin
            rd_en_r      <= rd_en_s;
            wr_en_r      <= wr_en_s;
            addr_r       <= addr_s;
            wdata_r      <= wdata_s;
            width_r      <= width_s;
            sgn_r        <= sgn_s;
            owner_r      <= owner_s;
            last_grant_r <= last_grant_s;
            wait_cnt_r   <= wait_cnt_s;
            rdata0_r     <= rdata0_s;
            rdata1_r     <= rdata1_s;
            ack0_r       <= ack0_s;
            ack1_r       <= ack1_s;
            err0_r       <= err0_s;
            err1_r       <= err1_s;
        end
    end

    assign bus.mmu_read_enable  = rd_en_r;
    assign bus.mmu_write_enable = wr_en_r;
    assign bus.mmu_address      = addr_r;
    assign bus.mmu_data_in      = wdata_r;
    assign bus.mmu_data_width   = width_r;
    assign bus.mmu_signed_read  = sgn_r;
    assign bus.m0_rdata         = rdata0_r;
    assign bus.m1_rdata         = rdata1_r;
    assign bus.m0_ack           = ack0_r;
    assign bus.m1_ack           = ack1_r;
    assign bus.m0_err           = err0_r;
    assign bus.m1_err           = err1_r;

endmodule

// File: tb/tb_mmu_arbiter.sv
// tb_mmu_arbiter: directed and randomized transactions on both ports of
// mmu_arbiter, compared against a transaction-level reference model.
`timescale 1ns/1ps

module tb_mmu_arbiter;

    localparam int T = 8;

    logic clk;
    logic reset_n;

    mmu_arbiter_if bus();

    mmu_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    // Reference model state: last granted port and each port's read data.
    logic        model_last;
    logic [31:0] model_rdata [2];

    // Current command fields presented on each port.
    logic        p_we    [2];
    logic [31:0] p_addr  [2];
    logic [31:0] p_wdata [2];
    logic [1:0]  p_width [2];
    logic        p_sgn   [2];

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Spec arbitration rule at transaction level.
    function automatic int pick_owner(input logic r0, input logic r1, input logic last);
        if (r0 && r1) begin
`ifdef MMU_ARBITER_RR_EN
            return (last == 1'b0) ? 1 : 0;
`else
            return 0;
`endif
        end
        return r0 ? 0 : 1;
    endfunction

    task automatic set_port(input int p, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] width, input logic sgn);
        p_we[p] = we; p_addr[p] = addr; p_wdata[p] = wdata; p_width[p] = width; p_sgn[p] = sgn;
        if (p == 0) begin
            bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
            bus.m0_width = width; bus.m0_signed = sgn;
        end else begin
            bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
            bus.m1_width = width; bus.m1_signed = sgn;
        end
    endtask

    task automatic rand_port(input int p);
        set_port(p, 1'($urandom_range(0, 1)), $urandom(), $urandom(),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    endtask

    task automatic check_quiet(input string tag);
        check1({tag, ".ack0"}, bus.m0_ack, 1'b0);
        check1({tag, ".ack1"}, bus.m1_ack, 1'b0);
        check1({tag, ".err0"}, bus.m0_err, 1'b0);
        check1({tag, ".err1"}, bus.m1_err, 1'b0);
    endtask

    // One full transaction. Entered and left at a negedge inside an IDLE
    // cycle. Ready is raised in BUSY cycle k (k=0: never).
    task automatic run_txn(input logic r0, input logic r1, input int k, input logic hold,
                           input logic [31:0] rd_data, input string tag);
        int          owner;
        logic        timed_out;
        int          en_cycles;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [1:0]  e_width;
        logic        e_sgn;

        bus.m0_req = r0;
        bus.m1_req = r1;
        bus.mmu_mem_ready = 1'($urandom_range(0, 1));
        bus.mmu_data_out  = $urandom();
        owner      = pick_owner(r0, r1, model_last);
        model_last = (owner == 1);
        e_we = p_we[owner]; e_addr = p_addr[owner]; e_wdata = p_wdata[owner];
        e_width = p_width[owner]; e_sgn = p_sgn[owner];
        timed_out = (k == 0) || (k > T);
        en_cycles = timed_out ? T : k;

        @(posedge clk); @(negedge clk);
        for (int i = 1; i <= en_cycles; i++) begin
            check1({tag, ".rd_en"}, bus.mmu_read_enable, ~e_we);
            check1({tag, ".wr_en"}, bus.mmu_write_enable, e_we);
            check32({tag, ".addr"}, bus.mmu_address, e_addr);
            if (i == 1) begin
                check32({tag, ".data_in"}, bus.mmu_data_in, e_wdata);
                check32({tag, ".width"}, {30'd0, bus.mmu_data_width}, {30'd0, e_width});
                check1({tag, ".signed"}, bus.mmu_signed_read, e_sgn);
                check_quiet({tag, ".busy"});
                if (!hold) begin
                    bus.m0_req = 1'b0;
                    bus.m1_req = 1'b0;
                end
            end
            rand_port(0);
            rand_port(1);
            bus.mmu_mem_ready = (i == k);
            bus.mmu_data_out  = (i == k) ? rd_data : $urandom();
            @(posedge clk); @(negedge clk);
        end

        // RESP cycle
        if (!timed_out && !e_we) model_rdata[owner] = rd_data;
        check1({tag, ".resp_rd_en"}, bus.mmu_read_enable, 1'b0);
        check1({tag, ".resp_wr_en"}, bus.mmu_write_enable, 1'b0);
        check1({tag, ".ack0"}, bus.m0_ack, (owner == 0) && !timed_out);
        check1({tag, ".ack1"}, bus.m1_ack, (owner == 1) && !timed_out);
        check1({tag, ".err0"}, bus.m0_err, (owner == 0) && timed_out);
        check1({tag, ".err1"}, bus.m1_err, (owner == 1) && timed_out);
        check32({tag, ".rdata0"}, bus.m0_rdata, model_rdata[0]);
        check32({tag, ".rdata1"}, bus.m1_rdata, model_rdata[1]);
        bus.mmu_mem_ready = 1'b1;
        bus.mmu_data_out  = $urandom();
        if (!hold) begin
            bus.m0_req = 1'b0;
            bus.m1_req = 1'b0;
        end
        @(posedge clk); @(negedge clk);

        // Following IDLE cycle: pulses gone, stray ready ignored
        check_quiet({tag, ".idle"});
        check1({tag, ".idle_rd_en"}, bus.mmu_read_enable, 1'b0);
        check32({tag, ".idle_rdata0"}, bus.m0_rdata, model_rdata[0]);
        check32({tag, ".idle_rdata1"}, bus.m1_rdata, model_rdata[1]);
        bus.mmu_mem_ready = 1'b0;
    endtask

    initial begin
        reset_n = 1'b1;
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        bus.mmu_mem_ready = 1'b0;
        bus.mmu_data_out  = 32'd0;
        set_port(0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
        set_port(1, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
        model_last = 1'b1;
        model_rdata[0] = 32'd0;
        model_rdata[1] = 32'd0;

        // Reset state
        #1 reset_n = 1'b0;
        #1;
        check1("rst.rd_en", bus.mmu_read_enable, 1'b0);
        check1("rst.wr_en", bus.mmu_write_enable, 1'b0);
        check32("rst.addr", bus.mmu_address, 32'd0);
        check32("rst.data_in", bus.mmu_data_in, 32'd0);
        check32("rst.rdata0", bus.m0_rdata, 32'd0);
        check32("rst.rdata1", bus.m1_rdata, 32'd0);
        check_quiet("rst");
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;

        // Idle with no request: enables stay low, ready is ignored
        for (int i = 0; i < 3; i++) begin
            bus.mmu_mem_ready = 1'b1;
            bus.mmu_data_out  = $urandom();
            @(posedge clk); @(negedge clk);
            check1("idle.rd_en", bus.mmu_read_enable, 1'b0);
            check1("idle.wr_en", bus.mmu_write_enable, 1'b0);
            check32("idle.rdata0", bus.m0_rdata, 32'd0);
            check_quiet("idle");
        end
        bus.mmu_mem_ready = 1'b0;

        // Port 0 read, ready in the 3rd BUSY cycle
        set_port(0, 1'b0, 32'h0000_0010, 32'd0, 2'd2, 1'b0);
        run_txn(1'b1, 1'b0, 3, 1'b0, 32'hDEAD_BEEF, "p0_read");

        // Port 1 write, ready in the first BUSY cycle
        set_port(1, 1'b1, 32'h0000_0020, 32'h1234_5678, 2'd2, 1'b0);
        run_txn(1'b0, 1'b1, 1, 1'b0, 32'hCAFE_F00D, "p1_write");

        // Both requests held for four transactions
        for (int j = 0; j < 4; j++) begin
            rand_port(0);
            rand_port(1);
            run_txn(1'b1, 1'b1, int'($urandom_range(1, 3)), (j < 3), $urandom(), "both_held");
        end

        // Timeout, then a normal transaction
        rand_port(0);
        run_txn(1'b1, 1'b0, 0, 1'b0, 32'h0BAD_0BAD, "timeout");
        set_port(0, 1'b0, 32'h0000_0030, 32'd0, 2'd1, 1'b1);
        run_txn(1'b1, 1'b0, 2, 1'b0, 32'h5555_AAAA, "after_timeout");

        // Ready on the very cycle the counter reaches the limit, and one past
        set_port(1, 1'b0, 32'h0000_0034, 32'd0, 2'd0, 1'b0);
        run_txn(1'b0, 1'b1, T, 1'b0, 32'h7777_1111, "ready_at_limit");
        set_port(1, 1'b0, 32'h0000_0038, 32'd0, 2'd0, 1'b0);
        run_txn(1'b0, 1'b1, T + 1, 1'b0, 32'h9999_2222, "ready_past_limit");

        // Reset during the 2nd BUSY cycle
        set_port(1, 1'b0, 32'h0000_0040, 32'd0, 2'd2, 1'b0);
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b1;
        bus.mmu_mem_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        check1("rst_busy.rd_en_before", bus.mmu_read_enable, 1'b1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check1("rst_busy.rd_en", bus.mmu_read_enable, 1'b0);
        check1("rst_busy.wr_en", bus.mmu_write_enable, 1'b0);
        check32("rst_busy.addr", bus.mmu_address, 32'd0);
        check32("rst_busy.rdata0", bus.m0_rdata, 32'd0);
        check32("rst_busy.rdata1", bus.m1_rdata, 32'd0);
        check_quiet("rst_busy");
        model_last = 1'b1;
        model_rdata[0] = 32'd0;
        model_rdata[1] = 32'd0;
        @(negedge clk); @(negedge clk);
        check_quiet("rst_busy_hold");
        reset_n = 1'b1;
        rand_port(0);
        rand_port(1);
        run_txn(1'b0, 1'b1, 2, 1'b0, 32'hA5A5_0001, "post_rst");

        // Randomized transactions
        for (int n = 0; n < 24; n++) begin
            logic [1:0] pat;
            pat = 2'($urandom_range(1, 3));
            rand_port(0);
            rand_port(1);
            run_txn(pat[0], pat[1], int'($urandom_range(0, T + 2)),
                    (n < 23) ? 1'($urandom_range(0, 1)) : 1'b0, $urandom(), "rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
